// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transfer sequencer and its Wishbone access engine.
// Register map and status bits follow the simple_spi_top register file.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT_SPCR = 4'd0,
        ST_INIT_SPER = 4'd1,
        ST_IDLE      = 4'd2,
        ST_WR_DATA   = 4'd3,
        ST_POLL      = 4'd4,
        ST_RD_DATA   = 4'd5,
        ST_CLR       = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERR       = 4'd8
    } state_t;

    localparam logic [7:0] ADR_SPCR = 8'd0;
    localparam logic [7:0] ADR_SPSR = 8'd1;
    localparam logic [7:0] ADR_SPDR = 8'd2;
    localparam logic [7:0] ADR_SPER = 8'd3;

    localparam int SPSR_SPIF    = 7;
    localparam int SPSR_WCOL    = 6;
    localparam int SPSR_RFEMPTY = 0;

    // Writing a one to SPIF clears the transfer-complete flag.
    localparam logic [7:0] SPSR_CLR_SPIF = 8'h80;

    // States that own exactly one Wishbone access.
    function automatic logic is_access(input state_t st);
        case (st)
            ST_INIT_SPCR, ST_INIT_SPER, ST_WR_DATA,
            ST_POLL, ST_RD_DATA, ST_CLR: is_access = 1'b1;
            default:                     is_access = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_single_access.sv
// Drives one classic Wishbone single access per start pulse, with a wait-cycle timeout.
// done pulses in the cycle after the access ends, which is also the mandatory cyc=0 cycle.
module wb_single_access
    import spi_seq_pkg::*;
#(
    parameter int ACK_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] adr,
    input  logic [7:0] dat,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic [7:0] bus_adr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_cyc,
    output logic       bus_stb,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    input  logic       bus_err
);

    localparam logic [7:0] WAIT_LAST = 8'(ACK_LIMIT - 1);

    logic       cyc_r;
    logic       we_r;
    logic       done_r;
    logic       err_r;
    logic [7:0] adr_r;
    logic [7:0] dat_r;
    logic [7:0] rdata_r;
    logic [7:0] wait_cnt_r;

    // Access engine: launch on start, finish on ack/err or after ACK_LIMIT unanswered cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r      <= 1'b0;
            we_r       <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            adr_r      <= 8'h00;
            dat_r      <= 8'h00;
            rdata_r    <= 8'h00;
            wait_cnt_r <= 8'h00;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            if (cyc_r) begin
                if (bus_ack || bus_err) begin
                    cyc_r      <= 1'b0;
                    done_r     <= 1'b1;
                    err_r      <= bus_err;
                    wait_cnt_r <= 8'h00;
                    if (!we_r) begin
                        rdata_r <= bus_rdata;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    cyc_r      <= 1'b0;
                    done_r     <= 1'b1;
                    err_r      <= 1'b1;
                    wait_cnt_r <= 8'h00;
                end else if (wait_cnt_r != 8'hFF) begin
                    wait_cnt_r <= wait_cnt_r + 8'd1;
                end
            end else if (start) begin
                cyc_r      <= 1'b1;
                we_r       <= we;
                adr_r      <= adr;
                dat_r      <= dat;
                wait_cnt_r <= 8'h00;
            end
        end
    end

    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign bus_adr   = adr_r;
    assign bus_wdata = dat_r;
    assign bus_we    = we_r;
    assign bus_cyc   = cyc_r;
    assign bus_stb   = cyc_r;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Wishbone master that initialises simple_spi_top and then exchanges one byte per client request.
// The next access is launched in the idle cycle of the previous one, giving two cycles per zero-wait access.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [7:0] SPCR_INIT  = 8'h50,
    parameter logic [7:0] SPER_INIT  = 8'h00,
    parameter int         POLL_LIMIT = 255,
    parameter int         ACK_LIMIT  = 15
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_valid_i,
    input  logic [7:0] req_data_i,
    output logic       req_ready_o,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    input  logic       wb_ack_i,
    input  logic       wb_err_i
);

    localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic       kick_r;
    logic [7:0] poll_cnt_r;
    logic       poll_retry_s;
    logic       launch_s;
    logic       acc_we_s;
    logic [7:0] acc_adr_s;
    logic [7:0] acc_dat_s;
    logic       acc_done_s;
    logic       acc_err_s;
    logic [7:0] acc_rdata_s;
    logic       req_ready_r;
    logic       rsp_valid_r;
    logic       rsp_err_r;
    logic [7:0] rsp_data_r;
    logic       busy_r;

    // Next-state decision; every access state leaves on its access completing.
    always_comb begin
        state_next_s = state_r;
        poll_retry_s = 1'b0;
        case (state_r)
            ST_INIT_SPCR: if (acc_done_s) state_next_s = acc_err_s ? ST_ERR : ST_INIT_SPER;
                          else            state_next_s = state_r;
            ST_INIT_SPER: if (acc_done_s) state_next_s = acc_err_s ? ST_ERR : ST_IDLE;
                          else            state_next_s = state_r;
            ST_IDLE:      if (req_valid_i) state_next_s = ST_WR_DATA;
                          else             state_next_s = state_r;
            ST_WR_DATA:   if (acc_done_s) state_next_s = acc_err_s ? ST_ERR : ST_POLL;
                          else            state_next_s = state_r;
            ST_POLL: begin
                if (!acc_done_s) begin
                    state_next_s = state_r;
                end else if (acc_err_s) begin
                    state_next_s = ST_ERR;
                end else if (!acc_rdata_s[SPSR_RFEMPTY]) begin
                    state_next_s = ST_RD_DATA;
                end else if (poll_cnt_r == POLL_LAST) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = state_r;
                    poll_retry_s = 1'b1;
                end
            end
            ST_RD_DATA:   if (acc_done_s) state_next_s = acc_err_s ? ST_ERR : ST_CLR;
                          else            state_next_s = state_r;
            ST_CLR:       if (acc_done_s) state_next_s = acc_err_s ? ST_ERR : ST_DONE;
                          else            state_next_s = state_r;
            ST_DONE:      state_next_s = ST_IDLE;
            ST_ERR:       state_next_s = ST_INIT_SPCR;
            default:      state_next_s = ST_INIT_SPCR;
        endcase
    end

    // Launch the access owned by the state being entered (or re-entered for a poll retry).
    always_comb begin
        launch_s  = 1'b0;
        acc_we_s  = 1'b0;
        acc_adr_s = ADR_SPCR;
        acc_dat_s = 8'h00;
        if (is_access(state_next_s) && ((state_next_s != state_r) || poll_retry_s || kick_r)) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
        case (state_next_s)
            ST_INIT_SPCR: begin acc_we_s = 1'b1; acc_adr_s = ADR_SPCR; acc_dat_s = SPCR_INIT;     end
            ST_INIT_SPER: begin acc_we_s = 1'b1; acc_adr_s = ADR_SPER; acc_dat_s = SPER_INIT;     end
            ST_WR_DATA:   begin acc_we_s = 1'b1; acc_adr_s = ADR_SPDR; acc_dat_s = req_data_i;    end
            ST_POLL:      begin acc_we_s = 1'b0; acc_adr_s = ADR_SPSR; acc_dat_s = 8'h00;         end
            ST_RD_DATA:   begin acc_we_s = 1'b0; acc_adr_s = ADR_SPDR; acc_dat_s = 8'h00;         end
            ST_CLR:       begin acc_we_s = 1'b1; acc_adr_s = ADR_SPSR; acc_dat_s = SPSR_CLR_SPIF; end
            default:      begin acc_we_s = 1'b0; acc_adr_s = ADR_SPCR; acc_dat_s = 8'h00;         end
        endcase
    end

    // State, poll counter and client-facing outputs, all registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_INIT_SPCR;
            kick_r      <= 1'b1;
            poll_cnt_r  <= 8'h00;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            kick_r      <= 1'b0;
            req_ready_r <= (state_next_s == ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_DONE) || (state_next_s == ST_ERR);
            rsp_err_r   <= (state_next_s == ST_ERR);
            if (state_next_s != state_r) begin
                poll_cnt_r <= 8'h00;
            end else if (poll_retry_s && (poll_cnt_r != 8'hFF)) begin
                poll_cnt_r <= poll_cnt_r + 8'd1;
            end
            if (state_next_s == ST_ERR) begin
                rsp_data_r <= 8'h00;
            end else if ((state_r == ST_RD_DATA) && acc_done_s) begin
                rsp_data_r <= acc_rdata_s;
            end
        end
    end

    wb_single_access #(
        .ACK_LIMIT (ACK_LIMIT)
    ) u_access (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .start     (launch_s),
        .we        (acc_we_s),
        .adr       (acc_adr_s),
        .dat       (acc_dat_s),
        .done      (acc_done_s),
        .err       (acc_err_s),
        .rdata     (acc_rdata_s),
        .bus_adr   (wb_adr_o),
        .bus_wdata (wb_dat_o),
        .bus_we    (wb_we_o),
        .bus_cyc   (wb_cyc_o),
        .bus_stb   (wb_stb_o),
        .bus_rdata (wb_dat_i),
        .bus_ack   (wb_ack_i),
        .bus_err   (wb_err_i)
    );

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_data_o  = rsp_data_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomised bench for spi_xfer_sequencer: a behavioural SPI-core slave plus a transaction-level
// model predicting the bus access list, the response and its latency for each request.
module tb_spi_xfer_sequencer;

    localparam int POLL_LIMIT = 4;
    localparam int ACK_LIMIT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_data;
    logic [7:0] wb_adr, wb_dat_o, wb_dat_i;
    logic       wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .SPCR_INIT (8'h50), .SPER_INIT (8'h00),
        .POLL_LIMIT(POLL_LIMIT), .ACK_LIMIT(ACK_LIMIT)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model of the SPI core register file ----------------
    int         sl_wait_req = 0;
    int         sl_n_empty  = 0;
    bit         sl_noack_w2 = 1'b0;
    bit         sl_err_r2   = 1'b0;
    logic [7:0] sl_spdr     = 8'h00;
    int         sl_wait     = 0;
    int         sl_polls    = 0;
    logic       sl_hold, sl_errhit;

    assign sl_hold   = sl_noack_w2 && wb_we && (wb_adr == 8'd2);
    assign sl_errhit = sl_err_r2 && !wb_we && (wb_adr == 8'd2);
    assign wb_ack    = wb_cyc && wb_stb && !sl_hold && !sl_errhit && (sl_wait >= sl_wait_req);
    assign wb_err    = wb_cyc && wb_stb && sl_errhit && (sl_wait >= sl_wait_req);
    assign wb_dat_i  = (wb_adr == 8'd1) ? ((sl_polls < sl_n_empty) ? 8'h05 : 8'h80) :
                       (wb_adr == 8'd2) ? sl_spdr : 8'h00;

    always @(posedge clk) begin
        if (wb_cyc && wb_stb && !(wb_ack || wb_err)) sl_wait <= sl_wait + 1;
        else                                         sl_wait <= 0;
        if (wb_ack && wb_we && (wb_adr == 8'd2))       sl_polls <= 0;
        else if (wb_ack && !wb_we && (wb_adr == 8'd1)) sl_polls <= sl_polls + 1;
    end

    // ---------------- bus and response monitors ----------------
    // access entry: {err, abandoned, we, adr, data-or-wait-count}
    logic [18:0] obs_q[$];
    logic [8:0]  rsp_q[$];
    int          rsp_t[$];
    int          cyc_cnt = 0;
    int          run_len = 0;
    logic        prev_cyc = 1'b0, prev_done = 1'b0, prev_we = 1'b0;
    logic [7:0]  prev_adr = 8'h00;
    logic [16:0] prev_sig = 17'h0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (prev_done) check_eq("cyc_drop_after_ack", {wb_cyc, wb_stb}, 2'b00);
        if (wb_cyc && prev_cyc && !prev_done) check_eq("bus_hold", {wb_we, wb_adr, wb_dat_o}, prev_sig);
        if (wb_cyc && (wb_ack || wb_err))
            obs_q.push_back({wb_err, 1'b0, wb_we, wb_adr, wb_err ? 8'h00 : (wb_we ? wb_dat_o : wb_dat_i)});
        else if (!wb_cyc && prev_cyc && !prev_done)
            obs_q.push_back({1'b0, 1'b1, prev_we, prev_adr, 8'(run_len)});
        if (wb_cyc && !(wb_ack || wb_err)) run_len <= run_len + 1;
        else                               run_len <= 0;
        prev_cyc  <= wb_cyc;
        prev_done <= wb_cyc && (wb_ack || wb_err);
        prev_we   <= wb_we;
        prev_adr  <= wb_adr;
        prev_sig  <= {wb_we, wb_adr, wb_dat_o};
        if (rsp_valid) begin
            rsp_q.push_back({rsp_err, rsp_data});
            rsp_t.push_back(cyc_cnt);
        end
    end

    function automatic logic [18:0] e_wr(input logic [7:0] a, input logic [7:0] d);
        return {2'b00, 1'b1, a, d};
    endfunction
    function automatic logic [18:0] e_rd(input logic [7:0] a, input logic [7:0] d);
        return {2'b00, 1'b0, a, d};
    endfunction

    // mode: 0 normal, 1 SPSR stuck empty, 2 SPDR write never acked, 3 slave error on SPDR read
    task automatic run_txn(input bit with_init, input int mode, input logic [7:0] d,
                           input logic [7:0] s, input int n_empty, input int wait_req);
        logic [18:0] exp_q[$];
        logic [8:0]  exp_rsp;
        int          lat, polls, t_acc, k, n;
        bit          is_err;
        sl_spdr = s; sl_wait_req = wait_req;
        sl_n_empty  = (mode == 1) ? 1000 : n_empty;
        sl_noack_w2 = (mode == 2); sl_err_r2 = (mode == 3);
        obs_q.delete(); rsp_q.delete(); rsp_t.delete();
        if (with_init) begin
            exp_q.push_back(e_wr(8'd0, 8'h50));
            exp_q.push_back(e_wr(8'd3, 8'h00));
        end
        is_err = (mode != 0);
        if (mode == 2) begin
            exp_q.push_back({2'b01, 1'b1, 8'd2, 8'(ACK_LIMIT)});
            lat = ACK_LIMIT + 2;
        end else begin
            exp_q.push_back(e_wr(8'd2, d));
            polls = (mode == 1) ? POLL_LIMIT : n_empty;
            for (int i = 0; i < polls; i++) exp_q.push_back(e_rd(8'd1, 8'h05));
            if (mode == 1) begin
                lat = (1 + POLL_LIMIT) * (2 + wait_req) + 1;
            end else begin
                exp_q.push_back(e_rd(8'd1, 8'h80));
                if (mode == 3) begin
                    exp_q.push_back({2'b10, 1'b0, 8'd2, 8'h00});
                    lat = (3 + polls) * (2 + wait_req) + 1;
                end else begin
                    exp_q.push_back(e_rd(8'd2, s));
                    exp_q.push_back(e_wr(8'd1, 8'h80));
                    lat = (4 + polls) * (2 + wait_req) + 1;
                end
            end
        end
        if (is_err) begin
            exp_q.push_back(e_wr(8'd0, 8'h50));
            exp_q.push_back(e_wr(8'd3, 8'h00));
            exp_rsp = {1'b1, 8'h00};
        end else begin
            exp_rsp = {1'b0, s};
        end

        req_valid = 1'b1; req_data = d;
        k = 0;
        while (!req_ready && k < 200) begin
            if (with_init && obs_q.size() < 2) check_eq("ready_low_in_init", req_ready, 1'b0);
            @(negedge clk); k++;
        end
        check_eq("accept", req_ready, 1'b1);
        t_acc = cyc_cnt;
        @(negedge clk);
        req_valid = 1'b0; req_data = 8'($urandom);
        check_eq("busy_after_accept", {busy, req_ready}, 2'b10);
        k = 0;
        while (!(req_ready && rsp_q.size() > 0) && k < 400) begin
            @(negedge clk); k++;
        end
        check_eq("rsp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            check_eq("rsp_err_data", rsp_q[0], exp_rsp);
            check_eq("rsp_latency", rsp_t[0] - t_acc, lat);
        end
        check_eq("idle_busy", busy, 1'b0);
        check_eq("access_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("access%0d", i), obs_q[i], exp_q[i]);
        sl_noack_w2 = 1'b0; sl_err_r2 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, k;
        rst = 1'b1; req_valid = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {wb_cyc, wb_stb, wb_we, req_ready, rsp_valid, rsp_err, busy, wb_adr, wb_dat_o, rsp_data},
                 32'h0);
        rst = 1'b0;
        // init writes, then the request raised during INIT, zero-wait best case
        run_txn(1'b1, 0, 8'hA5, 8'h3C, 0, 0);
        run_txn(1'b0, 0, 8'($urandom), 8'($urandom), 3, 0);
        run_txn(1'b0, 1, 8'($urandom), 8'($urandom), 0, 0);
        run_txn(1'b0, 2, 8'($urandom), 8'($urandom), 0, 0);
        run_txn(1'b0, 3, 8'($urandom), 8'($urandom), 1, 1);
        for (int i = 0; i < 24; i++) begin
            m = $urandom_range(0, 9);
            m = (m < 6) ? 0 : m - 6;
            run_txn(1'b0, m, 8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // reset in the middle of a poll
        sl_n_empty = 1000; sl_wait_req = 2;
        req_valid = 1'b1; req_data = 8'($urandom);
        k = 0;
        while (!(wb_cyc && !wb_we && wb_adr == 8'd1) && k < 100) begin
            @(negedge clk); k++;
        end
        check_eq("reached_poll", {wb_cyc, wb_we, wb_adr}, {1'b1, 1'b0, 8'd1});
        rst = 1'b1; req_valid = 1'b0;
        rsp_q.delete();
        @(negedge clk);
        check_eq("rst_mid_poll_cyc", {wb_cyc, wb_stb}, 2'b00);
        repeat (2) @(negedge clk);
        obs_q.delete();
        rst = 1'b0; sl_n_empty = 0;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk); k++;
        end
        check_eq("reinit_ready", req_ready, 1'b1);
        check_eq("no_rsp_after_reset", rsp_q.size(), 0);
        check_eq("reinit_count", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            check_eq("reinit_spcr", obs_q[0], e_wr(8'd0, 8'h50));
            check_eq("reinit_sper", obs_q[1], e_wr(8'd3, 8'h00));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
